// File: rtl/offset_ram_if.sv
// GPU-side bundle for offset_ram: shift requests, shuffle request, per-cell
// offset lookup and status flags.
interface offset_ram_if;
  logic       ram_write;
  logic [3:0] ram_write_pos;
  logic       ram_write_horizontal;
  logic       ram_write_increase;
  logic       ram_reset;
  logic [3:0] offset_pos_x;
  logic [3:0] offset_pos_y;
  logic [3:0] offset_x;
  logic [3:0] offset_y;
  logic       offset_all_zero;
  logic       busy;

  modport master (
    output ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase,
    output ram_reset, offset_pos_x, offset_pos_y,
    input  offset_x, offset_y, offset_all_zero, busy
  );

  modport slave (
    input  ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase,
    input  ram_reset, offset_pos_x, offset_pos_y,
    output offset_x, offset_y, offset_all_zero, busy
  );
endinterface

// File: rtl/offset_ram.sv
// Tile-offset store for the sliding puzzle: cyclic row/column shifts,
// LFSR-driven shuffle, combinational offset lookup and solved flag.
module offset_ram #(
  parameter int          GRID          = 16,
  parameter int          SHUFFLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic        sysclk,
  input logic        reset,
  offset_ram_if.slave bus
);

  localparam int         W      = $clog2(GRID);
  localparam int         CW     = $clog2(SHUFFLE_MOVES) + 1;
  localparam logic [3:0] MASK   = 4'(GRID - 1);
  localparam logic [4:0] GRID_L = 5'(GRID);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] INIT    = 2'd1;
  localparam logic [1:0] SHUFFLE = 2'd2;
  localparam logic [1:0] CHECK   = 2'd3;

  logic [3:0] sx [GRID][GRID];
  logic [3:0] sy [GRID][GRID];
  logic [3:0] nx [GRID][GRID];
  logic [3:0] ny [GRID][GRID];
  logic [GRID*GRID-1:0] match;

  logic [1:0]    state, state_n;
  logic [CW-1:0] count, count_n;
  logic          settle, settle_n;
  logic [15:0]   lfsr;
  logic          rr_q, rise;
  logic          busy_q, az_q;
  logic          all_match;

  logic          sh_en, sh_h, sh_inc, load_id;
  logic [3:0]    sh_pos;

  assign rise      = bus.ram_reset & ~rr_q;
  assign all_match = &match;

  always_comb begin
    state_n  = state;
    count_n  = count;
    settle_n = settle;
    sh_en    = 1'b0;
    sh_h     = bus.ram_write_horizontal;
    sh_inc   = bus.ram_write_increase;
    sh_pos   = bus.ram_write_pos;
    load_id  = reset;
    case (state)
      IDLE: begin
        if (bus.ram_write && ({1'b0, bus.ram_write_pos} < GRID_L)) sh_en = 1'b1;
      end
      INIT: begin
        load_id  = 1'b1;
        count_n  = '0;
        settle_n = 1'b0;
        state_n  = SHUFFLE;
      end
      SHUFFLE: begin
        sh_en   = 1'b1;
        sh_h    = lfsr[0];
        sh_inc  = lfsr[1];
        sh_pos  = lfsr[7:4] & MASK;
        count_n = count + 1'b1;
        if (count == CW'(SHUFFLE_MOVES - 1)) state_n = CHECK;
      end
      default: begin
        // A solved result gets one more random move plus a settle cycle
        // before the match bits are trusted again.
        if (settle) begin
          settle_n = 1'b0;
        end else if (all_match) begin
          sh_en    = 1'b1;
          sh_h     = lfsr[0];
          sh_inc   = lfsr[1];
          sh_pos   = lfsr[7:4] & MASK;
          settle_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
    if (rise) begin
      state_n = INIT;
      sh_en   = 1'b0;
    end
  end

  always_comb begin
    nx = sx;
    ny = sy;
    for (int unsigned y = 0; y < GRID; y++) begin
      for (int unsigned x = 0; x < GRID; x++) begin
        if (sh_en && sh_h && (sh_pos == 4'(y))) begin
          if (sh_inc) begin
            nx[W'(y)][W'(x)] = sx[W'(y)][W'((x + 1) % GRID)];
            ny[W'(y)][W'(x)] = sy[W'(y)][W'((x + 1) % GRID)];
          end else begin
            nx[W'(y)][W'(x)] = sx[W'(y)][W'((x + GRID - 1) % GRID)];
            ny[W'(y)][W'(x)] = sy[W'(y)][W'((x + GRID - 1) % GRID)];
          end
        end
        if (sh_en && !sh_h && (sh_pos == 4'(x))) begin
          if (sh_inc) begin
            nx[W'(y)][W'(x)] = sx[W'((y + 1) % GRID)][W'(x)];
            ny[W'(y)][W'(x)] = sy[W'((y + 1) % GRID)][W'(x)];
          end else begin
            nx[W'(y)][W'(x)] = sx[W'((y + GRID - 1) % GRID)][W'(x)];
            ny[W'(y)][W'(x)] = sy[W'((y + GRID - 1) % GRID)][W'(x)];
          end
        end
        if (load_id) begin
          nx[W'(y)][W'(x)] = 4'(x);
          ny[W'(y)][W'(x)] = 4'(y);
        end
      end
    end
  end

  // Reset reaches the cells through load_id, so the grid needs no reset branch.
  always_ff @(posedge sysclk) begin
    for (int unsigned y = 0; y < GRID; y++) begin
      for (int unsigned x = 0; x < GRID; x++) begin
        sx[W'(y)][W'(x)]  <= nx[W'(y)][W'(x)];
        sy[W'(y)][W'(x)]  <= ny[W'(y)][W'(x)];
        match[y*GRID + x] <= (nx[W'(y)][W'(x)] == 4'(x)) && (ny[W'(y)][W'(x)] == 4'(y));
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      settle <= 1'b0;
      lfsr   <= LFSR_SEED;
      busy_q <= 1'b0;
      az_q   <= 1'b1;
    end else begin
      state  <= state_n;
      count  <= count_n;
      settle <= settle_n;
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      busy_q <= (state_n != IDLE);
      az_q   <= (state_n == IDLE) && all_match;
    end
    // Tracking the level during reset keeps a request already high at
    // release from being seen as a fresh rising edge.
    rr_q <= bus.ram_reset;
  end

  logic [W-1:0] rx, ry;
  logic         in_range;

  assign rx       = bus.offset_pos_x[W-1:0];
  assign ry       = bus.offset_pos_y[W-1:0];
  assign in_range = ({1'b0, bus.offset_pos_x} < GRID_L) && ({1'b0, bus.offset_pos_y} < GRID_L);

  assign bus.offset_x        = in_range ? ((sx[ry][rx] - bus.offset_pos_x) & MASK) : '0;
  assign bus.offset_y        = in_range ? ((sy[ry][rx] - bus.offset_pos_y) & MASK) : '0;
  assign bus.offset_all_zero = az_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_offset_ram.sv
// Bench for offset_ram: directed and random shifts plus LFSR shuffles,
// checked against an array model of the grid and a cycle-indexed LFSR history.
module tb_offset_ram;
  localparam int          GA   = 16;
  localparam int          SM   = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  offset_ram_if ifa ();
  offset_ram_if ifb ();

  offset_ram #(.GRID(GA), .SHUFFLE_MOVES(SM), .LFSR_SEED(SEED)) dut_a (
    .sysclk(sysclk), .reset(reset), .bus(ifa)
  );
  offset_ram #(.GRID(8), .SHUFFLE_MOVES(4), .LFSR_SEED(SEED)) dut_b (
    .sysclk(sysclk), .reset(reset), .bus(ifb)
  );

  always #500 sysclk = ~sysclk;

  int          total  = 0;
  int          passed = 0;
  int          cyc    = 0;
  logic [15:0] mlfsr  = '0;
  logic [15:0] hist [0:4095];
  int          mx [GA][GA];
  int          my [GA][GA];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // hist[e] is the LFSR value in effect when edge number e occurs.
  always @(posedge sysclk) begin
    if (cyc < 4096) hist[cyc] = mlfsr;
    mlfsr = reset ? SEED : lfsr_step(mlfsr);
    cyc++;
  end

  initial begin
    #(1000 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_identity();
    for (int y = 0; y < GA; y++)
      for (int x = 0; x < GA; x++) begin
        mx[y][x] = x;
        my[y][x] = y;
      end
  endtask

  function automatic bit model_solved();
    for (int y = 0; y < GA; y++)
      for (int x = 0; x < GA; x++)
        if (mx[y][x] != x || my[y][x] != y) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_shift(input int pos, input bit h, input bit inc);
    int tx [GA][GA];
    int ty [GA][GA];
    int d;
    tx = mx;
    ty = my;
    d  = inc ? 1 : GA - 1;
    for (int i = 0; i < GA; i++) begin
      if (h) begin
        mx[pos][i] = tx[pos][(i + d) % GA];
        my[pos][i] = ty[pos][(i + d) % GA];
      end else begin
        mx[i][pos] = tx[(i + d) % GA][pos];
        my[i][pos] = ty[(i + d) % GA][pos];
      end
    end
  endtask

  task automatic model_rand_move(input int e);
    logic [15:0] v;
    v = hist[e];
    model_shift(int'(v[7:4]) & (GA - 1), v[0], v[1]);
  endtask

  // Grid after a shuffle whose rising edge was sampled on edge e0, and the
  // edge on which busy should drop.
  task automatic predict_shuffle(input int e0, output int fall);
    int e;
    model_identity();
    for (int k = 0; k < SM; k++) model_rand_move(e0 + 2 + k);
    e = e0 + 2 + SM;
    while (model_solved() && e < e0 + 400) begin
      model_rand_move(e);
      e += 2;
    end
    fall = e;
  endtask

  task automatic check_grid(input string tag);
    int bad = 0;
    int fx = 0, fy = 0, ex, ey, ax = 0, ay = 0, bx = 0, by = 0;
    for (int y = 0; y < GA; y++)
      for (int x = 0; x < GA; x++) begin
        ifa.offset_pos_x = 4'(x);
        ifa.offset_pos_y = 4'(y);
        #1;
        ex = (mx[y][x] - x) & (GA - 1);
        ey = (my[y][x] - y) & (GA - 1);
        if (ifa.offset_x !== 4'(ex) || ifa.offset_y !== 4'(ey)) begin
          if (bad == 0) begin
            fx = x; fy = y; ax = ifa.offset_x; ay = ifa.offset_y; bx = ex; by = ey;
          end
          bad++;
        end
      end
    total++;
    assert (bad == 0) passed++;
    else $error("FAIL grid_%s: %0d cells differ, first (%0d,%0d) got %0d/%0d expected %0d/%0d",
                tag, bad, fx, fy, ax, ay, bx, by);
  endtask

  task automatic run_shuffle(input int hold, input bit wr_at_start, input string tag);
    int e0, n, fall;
    e0 = cyc;
    ifa.ram_reset = 1'b1;
    if (wr_at_start) begin
      ifa.ram_write            = 1'b1;
      ifa.ram_write_pos        = 4'd3;
      ifa.ram_write_horizontal = 1'b1;
      ifa.ram_write_increase   = 1'b1;
    end
    tick();
    ifa.ram_write = 1'b0;
    chk({tag, "_busy_rise"}, ifa.busy, 1);
    n = 1;
    while (ifa.busy === 1'b1 && n < 400) begin
      if (n == hold) ifa.ram_reset = 1'b0;
      if (n == 30 || n == 31) begin
        ifa.ram_write            = 1'b1;
        ifa.ram_write_pos        = 4'($urandom_range(0, 15));
        ifa.ram_write_horizontal = 1'($urandom_range(0, 1));
        ifa.ram_write_increase   = 1'($urandom_range(0, 1));
      end else begin
        ifa.ram_write = 1'b0;
      end
      tick();
      n++;
    end
    ifa.ram_write = 1'b0;
    chk({tag, "_busy_fell"}, ifa.busy, 0);
    predict_shuffle(e0, fall);
    chk({tag, "_fall_edge"}, cyc - 1, fall);
    chk({tag, "_min_len"}, (cyc - 1 - e0) >= SM + 2, 1);
    chk({tag, "_az"}, ifa.offset_all_zero, 0);
    check_grid(tag);
    if (ifa.ram_reset) begin
      repeat (4) tick();
      chk({tag, "_no_retrigger"}, ifa.busy, 0);
      ifa.ram_reset = 1'b0;
      tick();
    end
  endtask

  initial begin
    int bad, p, h, inc;
    {ifa.ram_write, ifa.ram_write_pos, ifa.ram_write_horizontal, ifa.ram_write_increase} = '0;
    {ifa.ram_reset, ifa.offset_pos_x, ifa.offset_pos_y} = '0;
    {ifb.ram_write, ifb.ram_write_pos, ifb.ram_write_horizontal, ifb.ram_write_increase} = '0;
    {ifb.ram_reset, ifb.offset_pos_x, ifb.offset_pos_y} = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    model_identity();
    chk("rst_busy", ifa.busy, 0);
    chk("rst_az", ifa.offset_all_zero, 1);
    chk("rst_b_az", ifb.offset_all_zero, 1);
    check_grid("reset");

    // Row 3 shift, increase
    ifa.ram_write = 1'b1; ifa.ram_write_pos = 4'd3;
    ifa.ram_write_horizontal = 1'b1; ifa.ram_write_increase = 1'b1;
    tick();
    ifa.ram_write = 1'b0;
    model_shift(3, 1'b1, 1'b1);
    ifa.offset_pos_x = 4'd0;  ifa.offset_pos_y = 4'd3; #1;
    chk("row_inc_cell0", ifa.offset_x, 1);
    ifa.offset_pos_x = 4'd15; #1;
    chk("row_inc_cell15", ifa.offset_x, 1);
    check_grid("row_inc");
    chk("row_inc_az_e1", ifa.offset_all_zero, 1);
    tick();
    chk("row_inc_az_e2", ifa.offset_all_zero, 0);

    // Undo with increase=0
    ifa.ram_write = 1'b1; ifa.ram_write_increase = 1'b0;
    tick();
    ifa.ram_write = 1'b0;
    model_shift(3, 1'b1, 1'b0);
    check_grid("row_undo");
    chk("row_undo_az_e1", ifa.offset_all_zero, 0);
    tick();
    chk("row_undo_az_e2", ifa.offset_all_zero, 1);

    // 16 consecutive column shifts on column 5 (held write)
    ifa.ram_write = 1'b1; ifa.ram_write_pos = 4'd5;
    ifa.ram_write_horizontal = 1'b0; ifa.ram_write_increase = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      model_shift(5, 1'b0, 1'b1);
      if (i == 7) check_grid("col_half");
    end
    ifa.ram_write = 1'b0;
    check_grid("col_full");
    tick();
    chk("col_az", ifa.offset_all_zero, 1);

    // Random user shifts
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(0, 15); h = $urandom_range(0, 1); inc = $urandom_range(0, 1);
      ifa.ram_write = 1'b1; ifa.ram_write_pos = 4'(p);
      ifa.ram_write_horizontal = 1'(h); ifa.ram_write_increase = 1'(inc);
      tick();
      ifa.ram_write = 1'b0;
      model_shift(p, 1'(h), 1'(inc));
    end
    check_grid("random");
    tick();
    chk("random_az", ifa.offset_all_zero, model_solved());

    // GRID=8 instance: out-of-range shift and lookup
    ifb.ram_write = 1'b1; ifb.ram_write_pos = 4'd0;
    ifb.ram_write_horizontal = 1'b1; ifb.ram_write_increase = 1'b1;
    tick();
    ifb.ram_write_pos = 4'd15;
    tick();
    ifb.ram_write = 1'b0;
    tick();
    bad = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        ifb.offset_pos_x = 4'(x); ifb.offset_pos_y = 4'(y); #1;
        if (ifb.offset_x !== ((y == 0) ? 4'd1 : 4'd0) || ifb.offset_y !== 4'd0) bad++;
      end
    chk("b_grid_bad_cells", bad, 0);
    chk("b_az", ifb.offset_all_zero, 0);
    ifb.offset_pos_x = 4'd9; ifb.offset_pos_y = 4'd0; #1;
    chk("b_oob_x", {ifb.offset_x, ifb.offset_y}, 0);
    ifb.offset_pos_x = 4'd0; ifb.offset_pos_y = 4'd12; #1;
    chk("b_oob_y", {ifb.offset_x, ifb.offset_y}, 0);

    // Shuffle: ram_reset high 10 cycles, simultaneous write dropped
    run_shuffle(10, 1'b1, "shuf1");

    // Reset mid-shuffle, with ram_reset still high at release
    ifa.ram_reset = 1'b1;
    repeat (20) tick();
    chk("mid_busy_before", ifa.busy, 1);
    reset = 1'b1;
    tick();
    model_identity();
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_az", ifa.offset_all_zero, 1);
    check_grid("mid_rst");
    reset = 1'b0;
    repeat (2) tick();
    chk("mid_no_trigger", ifa.busy, 0);
    ifa.ram_reset = 1'b0;
    tick();

    // Shuffle after reload, ram_reset held past completion
    run_shuffle(1000, 1'b0, "shuf2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
